// File: rtl/dac_request_arbiter_if.sv
// Signal bundle between dac_request_arbiter, its four requesters and the DAC interface.
interface dac_request_arbiter_if;
    logic        enable;
    logic [3:0]  req;
    logic [11:0] data_0;
    logic [11:0] data_1;
    logic [11:0] data_2;
    logic [11:0] data_3;
    logic        dac_start;
    logic [11:0] dac_data;
    logic        dac_tx_complete;
    logic [3:0]  done;
    logic [3:0]  grant;
    logic [3:0]  pending;
    logic [3:0]  overrun;
    logic        busy;
    logic        timeout_err;

    modport master (
        output enable, req, data_0, data_1, data_2, data_3, dac_tx_complete,
        input  dac_start, dac_data, done, grant, pending, overrun, busy, timeout_err
    );

    modport slave (
        input  enable, req, data_0, data_1, data_2, data_3, dac_tx_complete,
        output dac_start, dac_data, done, grant, pending, overrun, busy, timeout_err
    );
endinterface

// File: rtl/dac_request_arbiter.sv
// Four-channel request queue and arbiter in front of one MCP4725 DAC interface.
// Optional WAIT watchdog enabled by defining DAC_ARB_TIMEOUT_EN.
module dac_request_arbiter #(
    parameter int unsigned START_CYCLES   = 2,
    parameter int unsigned PRIORITY_MODE  = 0,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input logic                  clk,
    input logic                  rst,
    dac_request_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state;
    logic [1:0]  sel;
    logic [1:0]  ptr;
    logic [11:0] hold [4];
    logic [11:0] data_in [4];
    logic [3:0]  pending_r;
    logic [3:0]  grant_r;
    logic [3:0]  done_r;
    logic [3:0]  overrun_r;
    logic [11:0] inflight;
    logic        start_r;
    logic        busy_r;
    logic        cpl_prev;
    logic [3:0]  start_cnt;

    logic [3:0]  req;
    logic [3:0]  sel_onehot;
    logic [3:0]  load_clr;
    logic [1:0]  base;
    logic [1:0]  scan;
    logic [1:0]  pick;
    logic        pick_valid;
    logic        cpl_rise;

    assign req        = bus.req;
    assign data_in[0] = bus.data_0;
    assign data_in[1] = bus.data_1;
    assign data_in[2] = bus.data_2;
    assign data_in[3] = bus.data_3;
    assign sel_onehot = 4'b0001 << sel;
    assign cpl_rise   = bus.dac_tx_complete & ~cpl_prev;
    assign base       = (PRIORITY_MODE != 0) ? 2'd0 : ptr;

    // First pending channel at or after base, wrapping 3 -> 0.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        scan       = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            scan = base + 2'(i);
            if (!pick_valid && pending_r[scan]) begin
                pick       = scan;
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        load_clr = '0;
        if (state == S_LOAD) load_clr = sel_onehot;
    end

`ifdef DAC_ARB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] wait_cnt;
    logic          terr_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            sel       <= '0;
            ptr       <= '0;
            pending_r <= '0;
            grant_r   <= '0;
            done_r    <= '0;
            overrun_r <= '0;
            inflight  <= '0;
            start_r   <= 1'b0;
            busy_r    <= 1'b0;
            cpl_prev  <= 1'b0;
            start_cnt <= '0;
            for (int unsigned n = 0; n < 4; n++) hold[n] <= '0;
`ifdef DAC_ARB_TIMEOUT_EN
            wait_cnt  <= '0;
            terr_r    <= 1'b0;
`endif
        end else begin
            done_r    <= '0;
            overrun_r <= req & pending_r;
            cpl_prev  <= bus.dac_tx_complete;
            // A strobe coinciding with LOAD re-queues the channel: set wins over clear.
            pending_r <= (pending_r & ~load_clr) | req;
            for (int unsigned n = 0; n < 4; n++) begin
                if (req[n]) hold[n] <= data_in[n];
            end
`ifdef DAC_ARB_TIMEOUT_EN
            terr_r    <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (bus.enable && pick_valid) begin
                        sel    <= pick;
                        busy_r <= 1'b1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    inflight  <= hold[sel];
                    grant_r   <= sel_onehot;
                    start_r   <= 1'b1;
                    start_cnt <= '0;
                    state     <= S_START;
                end
                S_START: begin
                    if (start_cnt == 4'(START_CYCLES - 1)) begin
                        start_r <= 1'b0;
                        state   <= S_WAIT;
`ifdef DAC_ARB_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end else begin
                        start_cnt <= start_cnt + 4'd1;
                    end
                end
                S_WAIT: begin
                    if (cpl_rise) begin
                        done_r <= sel_onehot;
                        state  <= S_DONE;
                    end
`ifdef DAC_ARB_TIMEOUT_EN
                    else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        terr_r  <= 1'b1;
                        grant_r <= '0;
                        busy_r  <= 1'b0;
                        ptr     <= sel + 2'd1;
                        state   <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                    ptr     <= sel + 2'd1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.dac_start = start_r;
    assign bus.dac_data  = inflight;
    assign bus.done      = done_r;
    assign bus.grant     = grant_r;
    assign bus.pending   = pending_r;
    assign bus.overrun   = overrun_r;
    assign bus.busy      = busy_r;
`ifdef DAC_ARB_TIMEOUT_EN
    assign bus.timeout_err = terr_r;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dac_request_arbiter.sv
// Bench for dac_request_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each checked every cycle against a timeline model, plus literal spot checks.
module tb_dac_request_arbiter;
    localparam int SC = 2;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [3:0]  req = '0;
    logic [11:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic        cpl = 1'b0;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    dac_request_arbiter_if bus0();
    dac_request_arbiter_if bus1();

    assign bus0.enable = en;  assign bus1.enable = en;
    assign bus0.req = req;    assign bus1.req = req;
    assign bus0.data_0 = d0;  assign bus1.data_0 = d0;
    assign bus0.data_1 = d1;  assign bus1.data_1 = d1;
    assign bus0.data_2 = d2;  assign bus1.data_2 = d2;
    assign bus0.data_3 = d3;  assign bus1.data_3 = d3;
    assign bus0.dac_tx_complete = cpl;
    assign bus1.dac_tx_complete = cpl;

    dac_request_arbiter #(.START_CYCLES(SC), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(TO)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    dac_request_arbiter #(.START_CYCLES(SC), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(TO)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    // Model: per instance, a queue of pending samples and a conversion timeline m_t
    // (edges since the arbitration decision). Instance 1 uses fixed priority.
    logic [3:0]  m_pending [2];
    logic [11:0] m_hold [2][4];
    int          m_ptr [2];
    int          m_ch [2];
    int          m_t [2];
    bit          m_active [2];
    bit          m_finish [2];
    logic        m_prev;
    logic [3:0]  e_grant [2];
    logic [3:0]  e_done [2];
    logic [3:0]  e_overrun [2];
    logic        e_start [2];
    logic        e_busy [2];
    logic        e_terr [2];
    logic [11:0] e_data [2];

    task automatic model_clear(input int i);
        m_pending[i] = '0;
        for (int n = 0; n < 4; n++) m_hold[i][n] = '0;
        m_ptr[i] = 0; m_ch[i] = 0; m_t[i] = 0;
        m_active[i] = 1'b0; m_finish[i] = 1'b0;
        e_grant[i] = '0; e_done[i] = '0; e_overrun[i] = '0;
        e_start[i] = 1'b0; e_busy[i] = 1'b0; e_terr[i] = 1'b0; e_data[i] = '0;
    endtask

    task automatic model_inst(input int i);
        logic [3:0]  clr;
        logic [11:0] din [4];
        int          first;
        bit          found;
        din[0] = d0; din[1] = d1; din[2] = d2; din[3] = d3;
        if (rst) begin
            model_clear(i);
            return;
        end
        clr = '0;
        e_done[i] = '0;
        e_terr[i] = 1'b0;
        e_overrun[i] = req & m_pending[i];
        if (!m_active[i]) begin
            if (en && m_pending[i] != 0) begin
                first = (i == 1) ? 0 : m_ptr[i];
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && m_pending[i][(first + k) % 4]) begin
                        m_ch[i] = (first + k) % 4;
                        found = 1'b1;
                    end
                end
                m_active[i] = 1'b1; m_t[i] = 0; m_finish[i] = 1'b0;
                e_busy[i] = 1'b1;
            end
        end else begin
            m_t[i]++;
            if (m_finish[i]) begin
                e_grant[i] = '0; e_busy[i] = 1'b0;
                m_ptr[i] = (m_ch[i] + 1) % 4;
                m_active[i] = 1'b0; m_finish[i] = 1'b0;
            end else if (m_t[i] == 1) begin
                e_data[i] = m_hold[i][m_ch[i]];
                e_grant[i] = 4'(1 << m_ch[i]);
                clr = e_grant[i];
                e_start[i] = 1'b1;
            end else if (m_t[i] == SC + 1) begin
                e_start[i] = 1'b0;
            end else if (m_t[i] > SC + 1) begin
                if (cpl && !m_prev) begin
                    e_done[i] = e_grant[i];
                    m_finish[i] = 1'b1;
                end
`ifdef DAC_ARB_TIMEOUT_EN
                else if (m_t[i] - (SC + 1) == TO) begin
                    e_terr[i] = 1'b1; e_grant[i] = '0; e_busy[i] = 1'b0;
                    m_ptr[i] = (m_ch[i] + 1) % 4;
                    m_active[i] = 1'b0;
                end
`endif
            end
        end
        for (int n = 0; n < 4; n++) if (req[n]) m_hold[i][n] = din[n];
        m_pending[i] = (m_pending[i] & ~clr) | req;
    endtask

    task automatic compare_all();
        logic [30:0] a, e;
        for (int i = 0; i < 2; i++) begin
            if (i == 0)
                a = {bus0.grant, bus0.pending, bus0.done, bus0.overrun, bus0.dac_start,
                     bus0.busy, bus0.timeout_err, bus0.dac_data};
            else
                a = {bus1.grant, bus1.pending, bus1.done, bus1.overrun, bus1.dac_start,
                     bus1.busy, bus1.timeout_err, bus1.dac_data};
            e = {e_grant[i], m_pending[i], e_done[i], e_overrun[i], e_start[i],
                 e_busy[i], e_terr[i], e_data[i]};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL outputs inst%0d t=%0t actual=%h required=%h", i, $time, a, e);
            end
        end
    endtask

    // Inputs change only after the falling edge; the model steps on the rising edge.
    task automatic tick();
        @(posedge clk);
        model_inst(0);
        model_inst(1);
        m_prev = rst ? 1'b0 : cpl;
        if (rst) chk_en = 1'b1;
        @(negedge clk);
        if (chk_en) compare_all();
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=expired required=event", name);
    endtask

    task automatic wait_grant();
        int n = 0;
        while (bus0.grant == 4'b0000 && n < 20) begin tick(); n++; end
        if (n >= 20) bound_fail("wait_grant");
    endtask

    task automatic finish_conv(input logic [3:0] rereq);
        int n = 0;
        while (!((bus0.grant != 0 && !bus0.dac_start && bus0.done == 0) ||
                 (bus1.grant != 0 && !bus1.dac_start && bus1.done == 0)) && n < 30) begin
            tick(); n++;
        end
        if (n >= 30) bound_fail("wait_conv");
        tick();
        cpl = 1'b1; tick();
        cpl = 1'b0; req = rereq; tick();
        req = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        int n_seen, done_seen;
        model_clear(0); model_clear(1); m_prev = 1'b0;
        do_reset();
        lit("reset_busy", 32'(bus0.busy), 0);
        lit("reset_pending", 32'(bus0.pending), 0);

        // single request
        req = 4'b0001; d0 = 12'hABC; tick(); req = '0;
        lit("single_pending", 32'(bus0.pending), 32'h1);
        tick(); tick();
        lit("single_start", 32'(bus0.dac_start), 1);
        lit("single_data", 32'(bus0.dac_data), 32'hABC);
        lit("single_data_model", 32'(e_data[0]), 32'hABC);
        tick();
        lit("single_start2", 32'(bus0.dac_start), 1);
        tick();
        lit("single_start_end", 32'(bus0.dac_start), 0);
        tick();
        cpl = 1'b1; tick(); cpl = 1'b0;
        lit("single_done", 32'(bus0.done), 32'h1);
        tick();
        lit("single_busy_fall", 32'(bus0.busy), 0);
        lit("single_done_end", 32'(bus0.done), 0);

        // round-robin from reset
        do_reset();
        req = 4'b1111; d0 = 12'd1; d1 = 12'd2; d2 = 12'd3; d3 = 12'd4; tick(); req = '0;
        for (int k = 0; k < 4; k++) begin
            wait_grant();
            lit("rr_grant", 32'(bus0.grant), 32'(1 << k));
            lit("rr_data", 32'(bus0.dac_data), 32'(k + 1));
            lit("rr_grant_model", 32'(e_grant[0]), 32'(1 << k));
            finish_conv(4'b0000);
        end

        // fixed priority with ch0 re-requesting
        req = 4'b1111; d0 = 12'h010; d1 = 12'h011; d2 = 12'h012; d3 = 12'h013; tick(); req = '0;
        for (int k = 0; k < 3; k++) begin
            wait_grant();
            lit("prio_grant_ch0", 32'(bus1.grant), 32'h1);
            lit("rr_rotates", 32'(bus0.grant), 32'(1 << k));
            finish_conv((k < 2) ? 4'b0001 : 4'b0000);
        end
        for (int k = 0; k < 3; k++) finish_conv(4'b0000);
        lit("drain_pending0", 32'(bus0.pending), 0);
        lit("drain_pending1", 32'(bus1.pending), 0);

        // overrun while ch1 in flight
        req = 4'b0010; d1 = 12'h111; tick(); req = '0;
        wait_grant();
        req = 4'b0100; d2 = 12'h100; tick(); req = '0; tick();
        req = 4'b0100; d2 = 12'h200; tick(); req = '0;
        lit("overrun_pulse", 32'(bus0.overrun), 32'h4);
        tick();
        lit("overrun_clear", 32'(bus0.overrun), 0);
        finish_conv(4'b0000);
        wait_grant();
        lit("overrun_grant", 32'(bus0.grant), 32'h4);
        lit("overrun_latest", 32'(bus0.dac_data), 32'h200);
        finish_conv(4'b0000);

        // re-request on the granted channel
        req = 4'b1000; d3 = 12'h333; tick(); req = '0;
        wait_grant();
        tick(); tick();
        req = 4'b1000; d3 = 12'h055; tick(); req = '0;
        lit("rereq_data_hold", 32'(bus0.dac_data), 32'h333);
        finish_conv(4'b0000);
        wait_grant();
        lit("rereq_grant", 32'(bus0.grant), 32'h8);
        lit("rereq_data", 32'(bus0.dac_data), 32'h055);
        finish_conv(4'b0000);

        // enable low queues without granting
        en = 1'b0; req = 4'b0110; d1 = 12'h0A1; d2 = 12'h0A2; tick(); req = '0;
        tick(); tick(); tick();
        lit("dis_pending", 32'(bus0.pending), 32'h6);
        lit("dis_start", 32'(bus0.dac_start), 0);
        lit("dis_busy", 32'(bus0.busy), 0);
        en = 1'b1;
        wait_grant();
        lit("en_first", 32'(bus0.grant), 32'h2);
        finish_conv(4'b0000);
        wait_grant();
        lit("en_second", 32'(bus0.grant), 32'h4);
        lit("en_second_data", 32'(bus0.dac_data), 32'h0A2);
        finish_conv(4'b0000);

        // reset during WAIT
        req = 4'b0001; d0 = 12'h777; tick(); req = '0;
        wait_grant();
        tick(); tick();
        req = 4'b0100; tick(); req = '0;
        rst = 1'b1; tick();
        lit("rst_grant", 32'(bus0.grant), 0);
        lit("rst_pending", 32'(bus0.pending), 0);
        lit("rst_busy", 32'(bus0.busy), 0);
        lit("rst_data", 32'(bus0.dac_data), 0);
        rst = 1'b0; tick();
        lit("rst_done", 32'(bus0.done), 0);

`ifdef DAC_ARB_TIMEOUT_EN
        req = 4'b0001; d0 = 12'h3C3; tick(); req = '0;
        wait_grant();
        n_seen = -1; done_seen = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (bus0.timeout_err && n_seen < 0) n_seen = n;
            if (bus0.done != 0) done_seen = 1;
        end
        lit("timeout_latency", 32'(n_seen), 32'd18);
        lit("timeout_no_done", 32'(done_seen), 0);
        lit("timeout_idle", 32'(bus0.busy), 0);
`else
        n_seen = 0; done_seen = 0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/dac_request_arbiter.md
Name: dac_request_arbiter

Overview:
Shares one MCP4725 serial DAC interface between four requesters (UC, UART, FILTER, spare) and replaces static config-selected muxing with dynamic arbitration. Each requester posts a 12-bit sample with a one-cycle strobe. The block queues one sample per channel, selects the next channel, and sequences start/complete with the DAC interface. It returns a per-channel done pulse and sits between the requesters and the DAC interface instance in the DAC controller.

Parameters:
START_CYCLES, 2, number of cycles dac_start is held high per conversion (1..15).
PRIORITY_MODE, 0, 0 = round-robin; 1 = fixed priority, channel 0 highest.
TIMEOUT_CYCLES, 4096, watchdog limit in clk cycles (used only with DAC_ARB_TIMEOUT_EN).

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
enable  input  1  0 = no new grants; an in-flight conversion still completes
req  input  4  per-channel request strobe, one cycle wide
data_0 / data_1 / data_2 / data_3  input  12 each  sample for the matching channel, valid with req[n]
dac_start  output  1  start strobe to the DAC interface
dac_data  output  12  sample to the DAC interface, stable from the start strobe until completion
dac_tx_complete  input  1  completion level from the DAC interface
done  output  4  one-cycle pulse on the channel whose conversion finished
grant  output  4  one-hot; the channel currently in flight; 0 when idle
pending  output  4  channels holding a queued sample
overrun  output  4  one-cycle pulse when req[n] arrives while pending[n] = 1
busy  output  1  1 in any state other than IDLE
timeout_err  output  1  one-cycle pulse on a watchdog abort (macro builds only)

Behaviour:
- Reset: all outputs are 0. The FSM goes to IDLE, pending and all holding registers clear, and the round-robin pointer is set to channel 0. Reset mid-conversion abandons the conversion and no done pulse is issued.
- Capture: on req[n], data_n is latched into hold[n] and pending[n] is set on the next edge.
  - If pending[n] is already 1, the new data overwrites hold[n] (latest sample wins) and overrun[n] pulses on the same edge.
- Simultaneous strobes on several channels are all captured in the same cycle.
- A req on the granted channel during a conversion queues normally. It does not disturb dac_data, which is driven from a separate in-flight register.
- FSM states: IDLE -> LOAD -> START -> WAIT -> DONE -> IDLE.
- IDLE: if enable = 1 and pending is nonzero, choose a channel.
  - Round-robin: the first pending channel at or after the pointer, wrapping 3 -> 0.
  - Fixed priority: the lowest-numbered pending channel.
  - Go to LOAD.
- LOAD: copy hold[sel] into the in-flight register, clear pending[sel], set grant. Takes 1 cycle.
  - If req[sel] coincides with LOAD, the new sample is captured and pending[sel] stays 1 after the clear; set wins over clear.
- START: dac_start = 1 for exactly START_CYCLES cycles, then go to WAIT.
- WAIT: detect a rising edge of dac_tx_complete, using a registered previous value sampled on the rising edge of clk. On the edge, go to DONE.
  - If dac_tx_complete is already high on entry to WAIT, it does not count; a fresh 0 -> 1 transition is required.
- DONE: done[sel] pulses for 1 cycle, grant clears, the pointer moves to sel+1 mod 4, go to IDLE.
- Back-to-back throughput: minimum latency from req to dac_start is 3 cycles (capture edge, IDLE decision, LOAD). The next grant can start 1 cycle after DONE.
- enable deasserted: no new grants and requests still queue. Reasserting enable resumes arbitration with the pointer unchanged.
- Starvation: in round-robin mode, with all four channels requesting continuously, each channel is served once per four conversions.

Optional Feature:
DAC_ARB_TIMEOUT_EN.
- Defined: a counter runs in WAIT. If it reaches TIMEOUT_CYCLES without a completion edge, the FSM goes to IDLE.
  - timeout_err pulses for 1 cycle, grant clears, no done pulse is issued, the sample is dropped, and the pointer advances.
- Undefined: WAIT has no limit, timeout_err is tied to 0, and no counter is built.

Test Plan:
- Single request: req = 4'b0001 with data_0 = 12'hABC -> dac_start high 3 cycles later for 2 cycles with dac_data = 12'hABC; after the complete edge, done = 4'b0001 for 1 cycle and busy falls.
- Round-robin fairness: req = 4'b1111 in one cycle with data = 1, 2, 3, 4 -> grants in order ch0, ch1, ch2, ch3 and four done pulses in that order. With PRIORITY_MODE = 1 and ch0 re-requesting after each done, ch0 is always served first.
- Overrun: req[2] with 12'h100, then req[2] with 12'h200 while ch1 is in flight -> overrun[2] pulses once and ch2 outputs 12'h200.
- Re-request during flight: ch3 in WAIT, req[3] with 12'h055 -> dac_data stays at the old value until done; ch3 is then re-served with 12'h055.
- enable low with req = 4'b0110 -> pending = 4'b0110, dac_start stays 0; enable high -> ch1 then ch2 are served.
- Reset and timeout:
  - rst asserted during WAIT -> next cycle all outputs are 0 and pending = 0.
  - With DAC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16 and dac_tx_complete stuck at 0 -> timeout_err pulses 16 cycles after WAIT entry and no done pulse is issued.
